// File: rtl/shift_right_seq.sv
// Multi-cycle 32-bit logical/arithmetic right shifter.
// One power-of-two stage (16, 8, 4, 2, 1) is applied per clock.
module shift_right_seq (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] operand,
    input  logic [4:0]  shamt,
    input  logic        arith,
    output logic        busy,
    output logic        result_valid,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [2:0]  stage;
    logic [31:0] data;
    logic [31:0] data_nx;
    logic [4:0]  amt;
    logic        fill;
    logic [31:0] fillw;
    logic        accept;

    assign accept = start && (state != SHIFT);
    assign fillw  = {32{fill}};

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = SHIFT;
            SHIFT:   if (stage == 3'd4) state_nx = DONE;
            DONE:    state_nx = start ? SHIFT : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Stage k consumes amt[4-k] with distance 16>>k.
    always_comb begin
        data_nx = data;
        unique case (stage)
            3'd0: if (amt[4]) data_nx = {fillw[15:0], data[31:16]};
            3'd1: if (amt[3]) data_nx = {fillw[7:0], data[31:8]};
            3'd2: if (amt[2]) data_nx = {fillw[3:0], data[31:4]};
            3'd3: if (amt[1]) data_nx = {fillw[1:0], data[31:2]};
            3'd4: if (amt[0]) data_nx = {fillw[0], data[31:1]};
            default: data_nx = data;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            data  <= 32'd0;
            amt   <= 5'd0;
            fill  <= 1'b0;
            stage <= 3'd0;
        end else if (accept) begin
            data  <= operand;
            amt   <= shamt;
            fill  <= arith & operand[31];
            stage <= 3'd0;
        end else if (state == SHIFT) begin
            data  <= data_nx;
            stage <= stage + 3'd1;
        end
    end

    always_comb begin
        busy         = (state == SHIFT);
        result_valid = (state == DONE);
        result       = data;
    end

endmodule
